// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit. Signed and unsigned
//               32x32->64 multiply with configurable latency, 32-iteration
//               restoring divide with sign fix-up, and MTHI/MTLO writes.
//               HI/LO change only when an operation completes.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_LATENCY = 4          // legal range 1..8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_start,
    input  logic [2:0]  sig_md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Operation encodings presented by the Execute stage
    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    // Counter reload so that completion lands exactly MULT_LATENCY edges after accept
    localparam logic [5:0] c_MUL_RELOAD = 6'(MULT_LATENCY - 1);
    localparam logic [5:0] c_DIV_LAST   = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;        // multiply countdown / divide iteration index
    logic [31:0] r_opA;        // multiplicand, or dividend shifting into quotient
    logic [31:0] r_opB;        // multiplier, or divisor magnitude
    logic [31:0] r_rem;        // partial remainder of the restoring divide
    logic        r_signed;     // MULT (signed) vs MULTU
    logic        r_negQ;       // quotient must be negated in FIX
    logic        r_negR;       // remainder must be negated in FIX

    logic        w_isSignedDiv;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic signed [63:0] w_prodS;
    logic [63:0] w_prodU;
    logic [32:0] w_shifted;
    logic [32:0] w_diff;

    // DIV works on magnitudes; DIVU passes operands straight through.
    // Note |0x80000000| is 0x80000000 as an unsigned value, which is what we want.
    assign w_isSignedDiv = (sig_md_op == c_OP_DIV);
    assign w_absA = (w_isSignedDiv && src_a[31]) ? (-src_a) : src_a;
    assign w_absB = (w_isSignedDiv && src_b[31]) ? (-src_b) : src_b;

    // Products are formed from the captured operands, so they are stable for
    // the whole MUL phase and only sampled on the completion edge.
    assign w_prodS = $signed(r_opA) * $signed(r_opB);
    assign w_prodU = {32'd0, r_opA} * {32'd0, r_opB};

    // One restoring step: bring in the next dividend bit and trial-subtract.
    // A clear borrow (w_diff[32] == 0) means the divisor fits, quotient bit = 1.
    assign w_shifted = {r_rem, r_opA[31]};
    assign w_diff    = w_shifted - {1'b0, r_opB};

    // Control FSM plus all datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 6'd0;
            r_opA       <= 32'd0;
            r_opB       <= 32'd0;
            r_rem       <= 32'd0;
            r_signed    <= 1'b0;
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else begin
            // Status pulses last exactly one cycle unless re-asserted below
            done        <= 1'b0;
            div_by_zero <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (sig_start) begin
                        case (sig_md_op)
                            c_OP_MULT, c_OP_MULTU: begin
                                r_opA    <= src_a;
                                r_opB    <= src_b;
                                r_signed <= (sig_md_op == c_OP_MULT);
                                r_cnt    <= c_MUL_RELOAD;
                                busy     <= 1'b1;
                                r_state  <= MUL;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                if (src_b == 32'd0) begin
                                    // HI/LO untouched; report and stay ready
                                    done        <= 1'b1;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    r_opA   <= w_absA;
                                    r_opB   <= w_absB;
                                    r_rem   <= 32'd0;
                                    r_cnt   <= 6'd0;
                                    r_negQ  <= w_isSignedDiv && (src_a[31] ^ src_b[31]);
                                    r_negR  <= w_isSignedDiv && src_a[31];
                                    busy    <= 1'b1;
                                    r_state <= DIV;
                                end
                            end
                            c_OP_MTHI: hi <= src_a;
                            c_OP_MTLO: lo <= src_a;
                            default: ;   // reserved codes are dropped silently
                        endcase
                    end
                end

                MUL: begin
                    if (r_cnt == 6'd0) begin
                        {hi, lo} <= r_signed ? w_prodS : w_prodU;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end

                DIV: begin
                    r_opA <= {r_opA[30:0], ~w_diff[32]};
                    r_rem <= w_diff[32] ? w_shifted[31:0] : w_diff[31:0];
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_DIV_LAST) begin
                        r_state <= FIX;
                    end
                end

                FIX: begin
                    // Truncating division: quotient sign from sign mismatch,
                    // remainder takes the dividend's sign.
                    lo      <= r_negQ ? (-r_opA) : r_opA;
                    hi      <= r_negR ? (-r_rem) : r_rem;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed self-checking bench for mult_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int LAT = 4;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    logic        clk;
    logic        rst_n;
    logic        sig_start;
    logic [2:0]  sig_md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int nChecks = 0;
    int nPass   = 0;

    mult_div_unit #(.MULT_LATENCY(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sig_start   (sig_start),
        .sig_md_op   (sig_md_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive a request now (caller is away from an edge), hold it for one edge.
    task automatic startOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        sig_start = 1'b1;
        sig_md_op = op;
        src_a     = a;
        src_b     = b;
        @(posedge clk);
        #1;
        sig_start = 1'b0;
    endtask

    // Count edges until done is seen; flags busy gaps and stray div_by_zero.
    task automatic waitDone(input int maxCyc, output int cyc, output bit busyOk, output bit sawDbz);
        cyc    = 0;
        busyOk = 1'b1;
        sawDbz = 1'b0;
        while (cyc < maxCyc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (div_by_zero) sawDbz = 1'b1;
            if (done) break;
            if (!busy) busyOk = 1'b0;
        end
        check("doneSeen", {63'd0, done}, 64'd1);
    endtask

    int cyc;
    bit busyOk;
    bit sawDbz;
    bit sawDone;

    initial begin
        rst_n     = 1'b1;
        sig_start = 1'b0;
        sig_md_op = 3'b000;
        src_a     = 32'd0;
        src_b     = 32'd0;
        #2 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULT -2 * 3
        startOp(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy", {63'd0, busy}, 64'd1);
        check("mult_hiloHeld", {hi, lo}, 64'd0);
        waitDone(50, cyc, busyOk, sawDbz);
        check("mult_latency", 64'(cyc), 64'(LAT));
        check("mult_busyHigh", {63'd0, busyOk}, 64'd1);
        check("mult_busyLowOnDone", {63'd0, busy}, 64'd0);
        check("mult_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        @(posedge clk); #1;
        check("mult_donePulse", {63'd0, done}, 64'd0);

        // MULTU same operands
        startOp(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        waitDone(50, cyc, busyOk, sawDbz);
        check("multu_latency", 64'(cyc), 64'(LAT));
        check("multu_result", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        // MULT most-negative squared
        startOp(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        waitDone(50, cyc, busyOk, sawDbz);
        check("mult_minsq", {hi, lo}, 64'h4000_0000_0000_0000);

        // DIV -7 / 2
        startOp(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone(60, cyc, busyOk, sawDbz);
        check("div_latency", 64'(cyc), 64'd33);
        check("div_busyHigh", {63'd0, busyOk}, 64'd1);
        check("div_result", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIV 7 / -2: quotient negative, remainder positive
        startOp(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        waitDone(60, cyc, busyOk, sawDbz);
        check("div_negDivisor", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

        // DIVU 100 / 7 with an MTHI request injected mid-divide
        startOp(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        startOp(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("divu_midStartIgnored", {32'd0, hi}, 64'h0000_0000_0000_0001);
        waitDone(60, cyc, busyOk, sawDbz);
        check("divu_remainingCycles", 64'(cyc), 64'd23);
        check("divu_result", {hi, lo}, {32'd2, 32'd14});

        // Back-to-back: start MULTU in the done cycle
        check("b2b_doneNow", {63'd0, done}, 64'd1);
        startOp(OP_MULTU, 32'd5, 32'd6);
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        waitDone(50, cyc, busyOk, sawDbz);
        check("b2b_latency", 64'(cyc), 64'(LAT));
        check("b2b_result", {hi, lo}, 64'd30);

        // MTHI / MTLO preload then DIVU by zero
        startOp(OP_MTHI, 32'h1111_1111, 32'd0);
        check("mthi_write", {32'd0, hi}, 64'h1111_1111);
        check("mthi_noBusy", {62'd0, busy, done}, 64'd0);
        startOp(OP_MTLO, 32'h2222_2222, 32'd0);
        check("mtlo_write", {hi, lo}, 64'h1111_1111_2222_2222);
        startOp(OP_DIVU, 32'd55, 32'd0);
        check("dbz_flags", {61'd0, busy, done, div_by_zero}, 64'd3);
        check("dbz_hiloKept", {hi, lo}, 64'h1111_1111_2222_2222);
        @(posedge clk); #1;
        check("dbz_pulseEnd", {61'd0, busy, done, div_by_zero}, 64'd0);

        // Reserved opcode is ignored
        startOp(OP_RSVD, 32'hAAAA_AAAA, 32'h5555_5555);
        check("rsvd_noEffect", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("rsvd_hiloKept", {hi, lo}, 64'h1111_1111_2222_2222);

        // DIV 0x80000000 / -1 saturating case
        startOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone(60, cyc, busyOk, sawDbz);
        check("divmin_latency", 64'(cyc), 64'd33);
        check("divmin_noDbz", {63'd0, sawDbz}, 64'd0);
        check("divmin_result", {hi, lo}, 64'h0000_0000_8000_0000);

        // Asynchronous reset at iteration 16 of a DIV
        @(posedge clk); #1;
        startOp(OP_DIV, 32'd1000, 32'd3);
        repeat (16) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) sawDone = 1'b1;
        end
        check("arst_noDoneAfter", {63'd0, sawDone}, 64'd0);
        check("arst_hiloStill0", {hi, lo}, 64'd0);
        startOp(OP_MULTU, 32'd7, 32'd6);
        waitDone(50, cyc, busyOk, sawDbz);
        check("arst_firstOp", {hi, lo}, 64'd42);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
